// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: result select, funct3 sizes,
// and FSM states.
package mem_stage_lsu_pkg;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      LSU_IDLE,
      LSU_WAIT
   } lsu_state_e;

   // The reserved encoding 11 is treated as an ALU result.
   function automatic logic [1:0] norm_result_src(input logic [1:0] src);
      return (src == 2'b11) ? RES_ALU : src;
   endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Single-master data bus with req/ready handshake; ready may be held low for wait states.
interface mem_stage_lsu_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport master (output req, we, addr, be, wdata, input rdata, ready);
   modport slave  (input req, we, addr, be, wdata, output rdata, ready);
endinterface

// File: rtl/flopr.sv
// Resettable pipeline register with synchronous clear used to insert bubbles.
module flopr #(
   parameter int unsigned         WIDTH       = 32,
   parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         q <= RESET_VALUE;
      end else if (clr) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_stage_lsu_align.sv
// Store lane replication / byte-enable generation and load byte/half extraction with
// sign or zero extension.
module mem_stage_lsu_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic        we,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [31:0] byte_sh;
   logic [31:0] half_sh;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        sext;

   assign byte_sh = rdata >> {addr_lo, 3'b000};
   assign half_sh = rdata >> {addr_lo[1], 4'b0000};
   assign ld_byte = byte_sh[7:0];
   assign ld_half = half_sh[15:0];
   assign sext    = ~funct3[2];

   always_comb begin
      be    = 4'b1111;
      wdata = store_data;
      if (we) begin
         case (funct3[1:0])
            F3_B[1:0]: begin
               be    = 4'b0001 << addr_lo;
               wdata = {4{store_data[7:0]}};
            end
            F3_H[1:0]: begin
               be    = 4'b0011 << {addr_lo[1], 1'b0};
               wdata = {2{store_data[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (funct3[1:0])
         F3_B[1:0]: load_data = {{24{sext & ld_byte[7]}}, ld_byte};
         F3_H[1:0]: load_data = {{16{sext & ld_half[15]}}, ld_half};
         default:   load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: drives the data bus, stalls the pipeline on wait states or until
// timeout, and holds the M->W pipeline register.
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned RESET_VALUE    = 0
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   RegWriteM,
   input  logic [1:0]             ResultSrcM,
   input  logic                   MemWriteM,
   input  logic [2:0]             funct3M,
   input  logic [31:0]            ALUResultM,
   input  logic [31:0]            WriteDataM,
   input  logic [4:0]             RdM,
   input  logic [31:0]            PCPlus4M,
   mem_stage_lsu_if.master        bus,
   output logic                   StallM,
   output logic                   RegWriteW,
   output logic [1:0]             ResultSrcW,
   output logic [31:0]            ALUResultW,
   output logic [31:0]            ReadDataW,
   output logic [4:0]             RdW,
   output logic [31:0]            PCPlus4W,
   output logic                   MisalignW,
   output logic                   BusErrW
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_e  state;
   logic [7:0]  cnt;
   logic        access;
   logic        word;
   logic        half;
   logic        misalign;
   logic        misalign_idle;
   logic        in_wait;
   logic        timeout;
   logic        bubble;
   logic [31:0] rdata_eff;
   logic [31:0] load_data;

   assign access   = (ResultSrcM == RES_MEM) | MemWriteM;
   assign word     = funct3M[1];
   assign half     = (funct3M[1:0] == F3_H[1:0]);
   assign misalign = access & ((word & (ALUResultM[1:0] != 2'b00)) | (half & ALUResultM[0]));
   assign in_wait  = (state == LSU_WAIT);
   assign misalign_idle = misalign & ~in_wait;

   // Gating with n_rst drops any outstanding request the moment reset asserts.
   assign bus.req  = n_rst & (in_wait | (access & ~misalign));
   assign bus.we   = MemWriteM;
   assign bus.addr = {ALUResultM[31:2], 2'b00};
   assign timeout  = in_wait & ~bus.ready & (cnt == TIMEOUT_LAST);
   assign StallM   = bus.req & ~bus.ready & ~timeout;
   assign bubble   = StallM | misalign_idle | timeout;
   assign rdata_eff = bus.ready ? bus.rdata : 32'h0;

   mem_stage_lsu_align u_align (
      .funct3     (funct3M),
      .addr_lo    (ALUResultM[1:0]),
      .we         (MemWriteM),
      .store_data (WriteDataM),
      .rdata      (rdata_eff),
      .be         (bus.be),
      .wdata      (bus.wdata),
      .load_data  (load_data)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= LSU_IDLE;
         cnt       <= 8'd0;
         MisalignW <= 1'b0;
         BusErrW   <= 1'b0;
      end else begin
         MisalignW <= misalign_idle;
         BusErrW   <= timeout;
         case (state)
            LSU_IDLE: begin
               if (bus.req && !bus.ready) begin
                  state <= LSU_WAIT;
                  cnt   <= 8'd0;
               end
            end
            LSU_WAIT: begin
               if (bus.ready || timeout) begin
                  state <= LSU_IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= LSU_IDLE;
         endcase
      end
   end

   flopr #(.WIDTH(1), .RESET_VALUE(1'(RESET_VALUE))) u_regwrite_w (
      .clk(clk), .n_rst(n_rst), .clr(bubble), .d(RegWriteM), .q(RegWriteW)
   );

   flopr #(.WIDTH(2), .RESET_VALUE(2'(RESET_VALUE))) u_resultsrc_w (
      .clk(clk), .n_rst(n_rst), .clr(bubble), .d(norm_result_src(ResultSrcM)), .q(ResultSrcW)
   );

   flopr #(.WIDTH(32), .RESET_VALUE(32'(RESET_VALUE))) u_aluresult_w (
      .clk(clk), .n_rst(n_rst), .clr(bubble), .d(ALUResultM), .q(ALUResultW)
   );

   flopr #(.WIDTH(32), .RESET_VALUE(32'(RESET_VALUE))) u_readdata_w (
      .clk(clk), .n_rst(n_rst), .clr(bubble), .d(load_data), .q(ReadDataW)
   );

   flopr #(.WIDTH(5), .RESET_VALUE(5'(RESET_VALUE))) u_rd_w (
      .clk(clk), .n_rst(n_rst), .clr(bubble), .d(RdM), .q(RdW)
   );

   flopr #(.WIDTH(32), .RESET_VALUE(32'(RESET_VALUE))) u_pcplus4_w (
      .clk(clk), .n_rst(n_rst), .clr(bubble), .d(PCPlus4M), .q(PCPlus4W)
   );

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: zero-wait and wait-state loads, stores, misalign,
// timeout and reset during an outstanding access.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        RegWriteM;
   logic [1:0]  ResultSrcM;
   logic        MemWriteM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [4:0]  RdM;
   logic [31:0] PCPlus4M;
   logic        StallM;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW;
   logic [31:0] ReadDataW;
   logic [4:0]  RdW;
   logic [31:0] PCPlus4W;
   logic        MisalignW;
   logic        BusErrW;

   int n_cmp = 0;
   int n_bad = 0;

   mem_stage_lsu_if bus_if ();

   mem_stage_lsu #(.TIMEOUT_CYCLES(4), .RESET_VALUE(0)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .RegWriteM  (RegWriteM),
      .ResultSrcM (ResultSrcM),
      .MemWriteM  (MemWriteM),
      .funct3M    (funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .RdM        (RdM),
      .PCPlus4M   (PCPlus4M),
      .bus        (bus_if),
      .StallM     (StallM),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .RdW        (RdW),
      .PCPlus4W   (PCPlus4W),
      .MisalignW  (MisalignW),
      .BusErrW    (BusErrW)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input logic rw, input logic [1:0] rs, input logic mw,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pc4);
      RegWriteM  = rw;
      ResultSrcM = rs;
      MemWriteM  = mw;
      funct3M    = f3;
      ALUResultM = addr;
      WriteDataM = wd;
      RdM        = rd;
      PCPlus4M   = pc4;
   endtask

   task automatic set_nop();
      set_m(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_rst = 1'b0;
      set_nop();
      bus_if.ready = 1'b0;
      bus_if.rdata = 32'h0;
      #2;
      check("rst_req", {31'h0, bus_if.req}, 32'h0);
      check("rst_regwrite", {31'h0, RegWriteW}, 32'h0);
      check("rst_readdata", ReadDataW, 32'h0);
      check("rst_flags", {30'h0, MisalignW, BusErrW}, 32'h0);
      #10 n_rst = 1'b1;
      step();

      // LW zero-wait
      set_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h1000_0004, 32'h0, 5'd5, 32'h100);
      bus_if.ready = 1'b1;
      bus_if.rdata = 32'hDEAD_BEEF;
      #1;
      check("lw_req", {31'h0, bus_if.req}, 32'h1);
      check("lw_stall", {31'h0, StallM}, 32'h0);
      check("lw_addr", bus_if.addr, 32'h1000_0004);
      check("lw_be_we", {27'h0, bus_if.we, bus_if.be}, 32'h0000_000F);
      step();
      set_nop();
      bus_if.ready = 1'b0;
      bus_if.rdata = 32'h0;
      check("lw_data", ReadDataW, 32'hDEAD_BEEF);
      check("lw_ctl", {24'h0, RegWriteW, ResultSrcW, RdW}, {24'h0, 1'b1, 2'b01, 5'd5});

      // LB with 3 wait cycles
      set_m(1'b1, 2'b01, 1'b0, 3'b000, 32'h1000_0003, 32'h0, 5'd9, 32'h104);
      bus_if.rdata = 32'h1234_5678;
      #1;
      check("lb_stall0", {31'h0, StallM}, 32'h1);
      check("lb_addr0", bus_if.addr, 32'h1000_0000);
      step();
      check("lb_stall1", {31'h0, StallM}, 32'h1);
      check("lb_bubble1", {31'h0, RegWriteW}, 32'h0);
      check("lb_addr1", bus_if.addr, 32'h1000_0000);
      step();
      check("lb_stall2", {31'h0, StallM}, 32'h1);
      check("lb_req2", {31'h0, bus_if.req}, 32'h1);
      step();
      bus_if.ready = 1'b1;
      bus_if.rdata = 32'h80FF_0000;
      #1;
      check("lb_stall3", {31'h0, StallM}, 32'h0);
      step();
      set_nop();
      bus_if.ready = 1'b0;
      check("lb_data", ReadDataW, 32'hFFFF_FF80);
      check("lb_regwrite", {31'h0, RegWriteW}, 32'h1);

      // SH store lanes
      set_m(1'b0, 2'b00, 1'b1, 3'b001, 32'h1000_0002, 32'h1234_ABCD, 5'd0, 32'h108);
      bus_if.ready = 1'b1;
      #1;
      check("sh_we_be", {27'h0, bus_if.we, bus_if.be}, 32'h0000_001C);
      check("sh_wdata", bus_if.wdata, 32'hABCD_ABCD);
      check("sh_addr", bus_if.addr, 32'h1000_0000);
      check("sh_stall", {31'h0, StallM}, 32'h0);
      step();
      check("sh_regwrite", {31'h0, RegWriteW}, 32'h0);

      // SB at byte 1
      set_m(1'b0, 2'b00, 1'b1, 3'b000, 32'h1000_0001, 32'h0000_00A5, 5'd0, 32'h10C);
      #1;
      check("sb_be", {28'h0, bus_if.be}, 32'h2);
      check("sb_wdata", bus_if.wdata, 32'hA5A5_A5A5);
      step();

      // LHU upper half, zero-wait
      set_m(1'b1, 2'b01, 1'b0, 3'b101, 32'h1000_0002, 32'h0, 5'd3, 32'h110);
      bus_if.rdata = 32'h9ABC_0011;
      #1;
      step();
      check("lhu_data", ReadDataW, 32'h0000_9ABC);
      set_nop();
      bus_if.ready = 1'b0;

      // Misaligned LW
      set_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h1000_0006, 32'h0, 5'd4, 32'h114);
      #1;
      check("mis_req", {31'h0, bus_if.req}, 32'h0);
      check("mis_stall", {31'h0, StallM}, 32'h0);
      step();
      set_nop();
      check("mis_flag", {31'h0, MisalignW}, 32'h1);
      check("mis_regwrite", {31'h0, RegWriteW}, 32'h0);
      step();
      check("mis_pulse", {31'h0, MisalignW}, 32'h0);

      // LHU timeout with TIMEOUT_CYCLES=4
      set_m(1'b1, 2'b01, 1'b0, 3'b101, 32'h1000_0002, 32'h0, 5'd6, 32'h118);
      #1;
      check("to_stall0", {31'h0, StallM}, 32'h1);
      for (int i = 1; i <= 3; i++) begin
         step();
         check($sformatf("to_stall%0d", i), {31'h0, StallM}, 32'h1);
      end
      step();
      check("to_stall4", {31'h0, StallM}, 32'h0);
      check("to_err_early", {31'h0, BusErrW}, 32'h0);
      step();
      set_nop();
      #1;
      check("to_err", {31'h0, BusErrW}, 32'h1);
      check("to_regwrite", {31'h0, RegWriteW}, 32'h0);
      check("to_idle_req", {31'h0, bus_if.req}, 32'h0);
      step();
      check("to_err_pulse", {31'h0, BusErrW}, 32'h0);

      // Reset asserted mid-WAIT
      set_m(1'b1, 2'b01, 1'b0, 3'b010, 32'h1000_0008, 32'h0, 5'd8, 32'h11C);
      step();
      check("rw_stall", {31'h0, StallM}, 32'h1);
      n_rst = 1'b0;
      #1;
      check("rw_req", {31'h0, bus_if.req}, 32'h0);
      check("rw_stall_rst", {31'h0, StallM}, 32'h0);
      check("rw_w", {RegWriteW, ResultSrcW, RdW, ALUResultW[23:0]}, 32'h0);
      check("rw_w2", ReadDataW | PCPlus4W, 32'h0);
      #3 n_rst = 1'b1;
      set_m(1'b1, 2'b00, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd7, 32'h200);
      #1;
      check("alu_stall", {31'h0, StallM}, 32'h0);
      check("alu_req", {31'h0, bus_if.req}, 32'h0);
      step();
      check("alu_result", ALUResultW, 32'h0000_0055);
      check("alu_ctl", {24'h0, RegWriteW, ResultSrcW, RdW}, {24'h0, 1'b1, 2'b00, 5'd7});
      check("alu_pc4", PCPlus4W, 32'h200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. Consumes M-stage control (RegWriteM, ResultSrcM, MemWriteM) and datapath values.
- Drives a single-master data bus with a req/ready handshake and wait-state support. Stalls the pipeline while an access is outstanding.
- Contains the M->W pipeline register feeding the writeback mux.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before the access is abandoned. Legal range 1..255; counter is 8 bits.
- RESET_VALUE, 0: reset value of all W-stage registers.

Ports:
- clk  in  1  clock
- n_rst  in  1  async active-low reset
- RegWriteM  in  1  register write enable, M stage
- ResultSrcM  in  2  00 ALU, 01 load data, 10 PC+4, 11 reserved (treated as 00)
- MemWriteM  in  1  store enable
- funct3M  in  3  load/store size and sign
- ALUResultM  in  32  effective address / ALU result
- WriteDataM  in  32  store data (rs2)
- RdM  in  5  destination register
- PCPlus4M  in  32  PC+4
- bus_req  out  1  access request
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00})
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid when bus_ready=1
- bus_ready  in  1  access complete this cycle
- StallM  out  1  hold PC and F/D/E/M registers
- RegWriteW  out  1  W-stage write enable
- ResultSrcW  out  2  W-stage result select
- ALUResultW  out  32  W-stage ALU result
- ReadDataW  out  32  extended load data
- RdW  out  5  W-stage destination register
- PCPlus4W  out  32  W-stage PC+4
- MisalignW  out  1  misaligned access flag, 1-cycle pulse
- BusErrW  out  1  bus timeout flag, 1-cycle pulse

Behaviour:
- Access condition: access = (ResultSrcM==2'b01) | MemWriteM.
- Misalignment:
  - misalign = access & ((word & addr[1:0]!=0) | (half & addr[0])).
  - word is funct3[1:0]==10; half is funct3[1:0]==01.
  - funct3 011/110/111 are treated as word.
- FSM states: IDLE and WAIT. Reset state is IDLE.
- IDLE:
  - bus_req = access & ~misalign, asserted combinationally.
  - If bus_ready is also 1 in the same cycle: zero-wait completion, StallM=0, W register captures the result.
  - Otherwise: go to WAIT, StallM=1, counter cleared to 0.
- WAIT:
  - bus_req=1. bus_addr, bus_we, bus_be and bus_wdata are held stable because the M inputs are frozen by the stall.
  - StallM = ~bus_ready & ~timeout.
  - Counter increments each cycle.
  - On bus_ready: capture, return to IDLE.
  - On counter==TIMEOUT_CYCLES-1 without bus_ready: abandon the access, BusErrW=1 next cycle, RegWriteW=0, return to IDLE.
- StallM formula: StallM = bus_req & ~bus_ready & ~timeout.
- W register behaviour while StallM=1: loads a bubble (RegWriteW=0, ResultSrcW=00, other W fields don't-care but zeroed).
- Misaligned access: no bus_req, no stall. Next cycle MisalignW=1 and RegWriteW=0.
- Store byte enables:
  - SB: bus_be = 4'b0001<<addr[1:0], wdata = {4{WriteDataM[7:0]}}.
  - SH: bus_be = 4'b0011<<{addr[1],1'b0}, wdata = {2{WriteDataM[15:0]}}.
  - SW: bus_be = 4'b1111, wdata = WriteDataM.
  - Loads: bus_be = 4'b1111, bus_we = 0.
- Load extension:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - Bit funct3[2] selects zero-extension (1) or sign-extension (0).
- Stores complete with RegWriteW = RegWriteM (0 by decoder convention). No extra gating.
- Non-access instructions pass M->W in 1 cycle with no stall.
- Reset:
  - Asynchronous, forces IDLE, counter 0, all W outputs = RESET_VALUE, MisalignW = BusErrW = 0.
  - bus_req is 0 during reset, including reset asserted mid-WAIT. The outstanding access is dropped.
- bus_rdata is ignored when bus_ready=0.

Decomposition:
- Shared package:
  - ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4).
  - funct3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state typedef {LSU_IDLE, LSU_WAIT}.
- Sub-module lsu_align: combinational store lane/byte-enable generation and load extraction/extension.
- W-stage fields are built from the existing flopr register (clr driven by the bubble condition).

Test Plan:
- LW addr 0x1000_0004, bus_ready=1 same cycle, rdata 0xDEADBEEF -> StallM never 1; next cycle ReadDataW=0xDEADBEEF, RegWriteW=1.
- LB addr 0x1000_0003, rdata 0x80FF_0000, ready after 3 wait cycles -> StallM high 3 cycles, bus signals stable; then ReadDataW=0xFFFF_FF80, RegWriteW=1; bubble W during the stall.
- SH addr 0x1000_0002, WriteDataM=0x1234_ABCD -> bus_we=1, bus_be=4'b1100, bus_wdata=0xABCD_ABCD, bus_addr=0x1000_0000.
- LW addr 0x1000_0006 -> bus_req=0, StallM=0; next cycle MisalignW=1, RegWriteW=0.
- TIMEOUT_CYCLES=4, LHU with bus_ready held 0 -> StallM high 4 cycles then low; BusErrW=1 for one cycle, RegWriteW=0, FSM in IDLE.
- n_rst asserted during WAIT -> bus_req=0 immediately, all W outputs 0; after release, an ALU op passes with no stall.
